// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, glitch-rejecting start detection and a
// valid/ready holding register. Define UART_RX_PARITY_EN for 8E1 with a parity_err pulse.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned OSR      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       idle,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OSR);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned S_W   = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_START  = S_W'(OSR / 2 - 1);
  localparam logic [S_W-1:0]   S_BIT    = S_W'(OSR - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
`ifdef UART_RX_PARITY_EN
    , ST_PARITY
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             idle_q, idle_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             complete_c;
  logic             rx_c, tick_c, sample_c;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  assign rx_c     = sync_q[1];
  assign tick_c   = (div_q == DIV_LAST);
  // First sample lands mid start bit, later ones every OSR ticks at bit centres
  assign sample_c = tick_c && (s_q == ((state_q == ST_START) ? S_START : S_BIT));

  always_comb begin
    sync_d       = {sync_q[0], in};
    rx_prev_d    = rx_c;
    state_d      = state_q;
    div_d        = tick_c ? '0 : div_q + DIV_W'(1);
    s_d          = s_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    valid_d      = valid_q && !ready;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    complete_c   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    if (tick_c) s_d = sample_c ? '0 : s_q + S_W'(1);

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        s_d   = '0;
        if (rx_prev_q && !rx_c) state_d = ST_START;
      end
      ST_START: begin
        bit_d = 3'd0;
        if (sample_c) state_d = rx_c ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample_c) begin
          shift_d = {rx_c, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = ST_PARITY;
`else
          if (bit_q == 3'd7) state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_c) begin
          par_d   = rx_c;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (sample_c) begin
          if (rx_c) begin
            complete_c = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing byte replaces the held one only if it is free or being accepted now
    if (complete_c) begin
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end else begin
        data_out_d = shift_q;
        valid_d    = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      parity_err_d = ^{shift_q, par_q};
`endif
    end

    idle_d = (state_d == ST_IDLE) && sync_q[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      div_q        <= '0;
      s_q          <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      idle_q       <= 1'b1;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      rx_prev_q    <= rx_prev_d;
      div_q        <= div_d;
      s_q          <= s_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      idle_q       <= idle_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign idle      = idle_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, outputs observed on the falling clock edge.
// A reduced clock (DIV=13, 208 clk per bit) keeps the run short; DIV is still truncated.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 24_000_000;
  localparam int unsigned BAUD     = 115_200;
  localparam int unsigned OSR      = 16;
  localparam int unsigned DIV      = CLK_FREQ / (BAUD * OSR);
  localparam int unsigned BIT      = DIV * OSR;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned SLOTS = 10;
`else
  localparam int unsigned SLOTS = 9;
`endif
  // Line drive to valid: 2 synchronizer clk, then half a bit plus the remaining slots, plus 1
  localparam int LAT = 2 + int'((OSR / 2 + SLOTS * OSR) * DIV) + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       line;
  logic       ready;
  logic [7:0] data_out;
  logic       valid, idle, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int valid_hi = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] got[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OSR(OSR)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (line),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .idle      (idle),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted bytes and pulse counts
  always @(negedge clk) begin
    if (valid && ready) got.push_back(data_out);
    if (valid) valid_hi <= valid_hi + 1;
    if (valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= valid;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 8'bx;
  endfunction

  // Call at a rising edge; returns at a rising edge with the line left at the stop level
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
    #1 line = 1'b0;
    start_cyc = cyc;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 line = d[i];
      repeat (BIT) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    #1 line = (^d) ^ bad_par;
    repeat (BIT) @(posedge clk);
`else
    if (bad_par) line = line;
`endif
    #1 line = stop_b;
    repeat (BIT) @(posedge clk);
  endtask

  initial begin
    reset = 1'b0;
    line  = 1'b1;
    ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_idle", 32'(idle), 32'h1);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b1;
    repeat (5) @(posedge clk);

    // Single byte with ready held high
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (BIT) @(posedge clk);
    #1;
    check("a5_count", 32'(got.size()), 32'd1);
    check("a5_data", 32'(got_at(0)), 32'hA5);
    check("a5_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
    check("a5_valid_cycles", 32'(valid_hi), 32'd1);
    check("a5_frame_err", 32'(fe_cnt), 32'd0);
    check("a5_overrun", 32'(ov_cnt), 32'd0);
    check("a5_idle", 32'(idle), 32'h1);

    // Back-to-back frames with no idle gap
    @(posedge clk);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (BIT) @(posedge clk);
    #1;
    check("b2b_count", 32'(got.size()), 32'd4);
    check("b2b_0", 32'(got_at(1)), 32'h00);
    check("b2b_1", 32'(got_at(2)), 32'hFF);
    check("b2b_2", 32'(got_at(3)), 32'h55);

    // Short low glitch shorter than half a bit
    @(posedge clk);
    #1 line = 1'b0;
    repeat (60) @(posedge clk);
    #1 line = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    #1;
    check("glitch_count", 32'(got.size()), 32'd4);
    check("glitch_idle", 32'(idle), 32'h1);
    check("glitch_valid", 32'(valid), 32'h0);
    check("glitch_frame_err", 32'(fe_cnt), 32'd0);

    // Bad stop bit followed by a long break, then a good frame
    @(posedge clk);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20 * BIT) @(posedge clk);
    #1 line = 1'b1;
    repeat (BIT) @(posedge clk);
    #1;
    check("brk_frame_err", 32'(fe_cnt), 32'd1);
    check("brk_count", 32'(got.size()), 32'd4);
    check("brk_idle", 32'(idle), 32'h1);
    @(posedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (BIT) @(posedge clk);
    #1;
    check("brk_81_count", 32'(got.size()), 32'd5);
    check("brk_81_data", 32'(got_at(4)), 32'h81);
    check("brk_81_frame_err", 32'(fe_cnt), 32'd1);

    // Overrun: second byte completes while the first is still held
    ready = 1'b0;
    @(posedge clk);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (BIT) @(posedge clk);
    #1;
    check("ovr_data_out", 32'(data_out), 32'h11);
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_pulses", 32'(ov_cnt), 32'd1);
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    check("ovr_flush_count", 32'(got.size()), 32'd6);
    check("ovr_flush_data", 32'(got_at(5)), 32'h11);
    check("ovr_flush_valid", 32'(valid), 32'h0);

    // Rerun with ready asserted on the exact completion clock of the second byte
    @(posedge clk);
    send_frame(8'h11, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    #1;
    check("acc_data_out", 32'(data_out), 32'h22);
    check("acc_valid", 32'(valid), 32'h1);
    check("acc_overrun", 32'(ov_cnt), 32'd1);
    check("acc_count", 32'(got.size()), 32'd7);
    check("acc_first", 32'(got_at(6)), 32'h11);
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("acc_second", 32'(got_at(7)), 32'h22);

    // Reset in the middle of a frame while a byte is held
    ready = 1'b0;
    @(posedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    #1;
    check("mid_pre_valid", 32'(valid), 32'h1);
    @(posedge clk);
    fork
      send_frame(8'h7E, 1'b1, 1'b0);
      begin
        repeat (4 * BIT) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_data_out", 32'(data_out), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_idle", 32'(idle), 32'h1);
        check("mid_rst_frame_err", 32'(frame_err), 32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
      end
    join
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ready = 1'b1;
    repeat (BIT) @(posedge clk);
    #1;
    check("mid_post_count", 32'(got.size()), 32'd8);
    check("mid_post_valid", 32'(valid), 32'h0);
    @(posedge clk);
    send_frame(8'h7E, 1'b1, 1'b0);
    repeat (BIT) @(posedge clk);
    #1;
    check("mid_7e_count", 32'(got.size()), 32'd9);
    check("mid_7e_data", 32'(got_at(8)), 32'h7E);
    check("mid_frame_err", 32'(fe_cnt), 32'd1);
    check("mid_overrun", 32'(ov_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so a 0 parity bit is an even-parity error
    check("par_none_yet", 32'(pe_cnt), 32'd0);
    @(posedge clk);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (BIT) @(posedge clk);
    #1;
    check("par_err_pulses", 32'(pe_cnt), 32'd1);
    check("par_data_out", 32'(data_out), 32'h07);
    check("par_count", 32'(got.size()), 32'd10);
    check("par_data", 32'(got_at(9)), 32'h07);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
